ascon_engine_arbiter: RTL and testbench

- Shares one Ascon encrypt/decrypt engine among N_REQ independent requesters.
- Arbitration is round-robin; one job runs at a time.
- Per job: accepts the request, drives the engine start level, waits for engine completion, then returns text and tag with a valid/ready response handshake tagged with the requester id.
- Sits between the requester fabric and the engine's start/ready interface.

---
 rtl/ascon_arb_pkg.sv | 18 +
 rtl/ascon_engine_arbiter_rr_pick.sv | 29 ++
 rtl/ascon_engine_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_ascon_engine_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_arb_pkg.sv
// Shared types and helpers for the Ascon engine arbiter.
package ascon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Requester id width, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ascon_engine_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_grant, wrapping.
module ascon_rr_pick
    import ascon_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDW   = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_grant,
    output logic             any,
    output logic [IDW-1:0]   winner
);

    int unsigned idx;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_grant) + k) % N_REQ;
            if (!any && req[idx[IDW-1:0]]) begin
                any    = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/ascon_engine_arbiter.sv
// Round-robin arbiter sharing one Ascon encrypt/decrypt engine among N_REQ requesters.
// Optional RUN watchdog is compiled in with `define ASCON_ARB_TIMEOUT_EN.
module ascon_engine_arbiter
    import ascon_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned Y           = 40,
    parameter int unsigned TAG_W       = 128,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_mode,
    input  logic [N_REQ*Y-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       eng_enc_start,
    output logic                       eng_dec_start,
    output logic [Y-1:0]               eng_din,
    input  logic                       eng_enc_ready,
    input  logic                       eng_dec_ready,
    input  logic [Y-1:0]               eng_text,
    input  logic [TAG_W-1:0]           eng_tag,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [id_width(N_REQ)-1:0] rsp_id,
    output logic                       rsp_mode,
    output logic [Y-1:0]               rsp_text,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic                       rsp_timeout,
    output logic                       busy
);

    localparam int unsigned IDW = id_width(N_REQ);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               enc_start_q, enc_start_d;
    logic               dec_start_q, dec_start_d;
    logic [Y-1:0]       din_q, din_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_mode_q, rsp_mode_d;
    logic [Y-1:0]       rsp_text_q, rsp_text_d;
    logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               busy_q, busy_d;

    logic               pick_any;
    logic [IDW-1:0]     pick_id;
    logic               pick_mode;
    logic               sel_ready;
    logic               tmo_hit;

    ascon_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .winner     (pick_id)
    );

    assign pick_mode = req_mode[pick_id];
    // rsp_mode_q holds the running job's mode, so it selects which ready counts.
    assign sel_ready = (rsp_mode_q == MODE_DEC) ? eng_dec_ready : eng_enc_ready;

`ifdef ASCON_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = (state_q == RUN) ? tmo_cnt_q + 16'd1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic tmo_unused;
    assign tmo_unused = (TIMEOUT_CYC != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        req_ready_d   = '0;
        enc_start_d   = enc_start_q;
        dec_start_d   = dec_start_q;
        din_d         = din_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_mode_d    = rsp_mode_q;
        rsp_text_d    = rsp_text_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready_d[pick_id] = 1'b1;
                    rsp_id_d    = pick_id;
                    rsp_mode_d  = pick_mode;
                    din_d       = req_data[32'(pick_id)*Y +: Y];
                    enc_start_d = (pick_mode == MODE_ENC);
                    dec_start_d = (pick_mode == MODE_DEC);
                    state_d     = RUN;
                end
            end
            RUN: begin
                // Engine completion takes priority over a same-cycle timeout.
                if (sel_ready) begin
                    rsp_text_d    = eng_text;
                    rsp_tag_d     = eng_tag;
                    rsp_timeout_d = 1'b0;
                    enc_start_d   = 1'b0;
                    dec_start_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (tmo_hit) begin
                    rsp_text_d    = '0;
                    rsp_tag_d     = '0;
                    rsp_timeout_d = 1'b1;
                    enc_start_d   = 1'b0;
                    dec_start_d   = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    last_grant_d  = rsp_id_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= IDW'(N_REQ - 1);
            req_ready_q   <= '0;
            enc_start_q   <= 1'b0;
            dec_start_q   <= 1'b0;
            din_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_mode_q    <= 1'b0;
            rsp_text_q    <= '0;
            rsp_tag_q     <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            req_ready_q   <= req_ready_d;
            enc_start_q   <= enc_start_d;
            dec_start_q   <= dec_start_d;
            din_q         <= din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_mode_q    <= rsp_mode_d;
            rsp_text_q    <= rsp_text_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign eng_enc_start = enc_start_q;
    assign eng_dec_start = dec_start_q;
    assign eng_din       = din_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_mode      = rsp_mode_q;
    assign rsp_text      = rsp_text_q;
    assign rsp_tag       = rsp_tag_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ascon_engine_arbiter.sv
// Self-checking bench for ascon_engine_arbiter with a behavioural engine and arbitration model.
// Timeout scenarios run when ASCON_ARB_TIMEOUT_EN is defined.
module tb_ascon_engine_arbiter;

    localparam int N     = 2;
    localparam int Y     = 40;
    localparam int TAG_W = 128;
    localparam int TMO   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_mode;
    logic [N*Y-1:0]     req_data;
    logic [N-1:0]       req_ready;
    logic               eng_enc_start, eng_dec_start;
    logic [Y-1:0]       eng_din;
    logic               eng_enc_ready, eng_dec_ready;
    logic [Y-1:0]       eng_text;
    logic [TAG_W-1:0]   eng_tag;
    logic               rsp_valid, rsp_ready;
    logic [0:0]         rsp_id;
    logic               rsp_mode;
    logic [Y-1:0]       rsp_text;
    logic [TAG_W-1:0]   rsp_tag;
    logic               rsp_timeout;
    logic               busy;

    int checks = 0;
    int errors = 0;

    // Requester model: pending requests and round-robin pointer.
    bit             pv [N];
    logic           pm [N];
    logic [Y-1:0]   pd [N];
    int             ptr;

    // Engine model knobs.
    int             eng_lat   = 3;
    bit             eng_hang  = 0;
    bit             eng_noise = 0;
    bit             fix_en    = 0;
    logic [Y-1:0]   fix_text;
    logic [TAG_W-1:0] fix_tag;
    int             ecnt;

    always #5 clk = ~clk;

    ascon_engine_arbiter #(
        .N_REQ       (N),
        .Y           (Y),
        .TAG_W       (TAG_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_mode      (req_mode),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .eng_enc_start (eng_enc_start),
        .eng_dec_start (eng_dec_start),
        .eng_din       (eng_din),
        .eng_enc_ready (eng_enc_ready),
        .eng_dec_ready (eng_dec_ready),
        .eng_text      (eng_text),
        .eng_tag       (eng_tag),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_mode      (rsp_mode),
        .rsp_text      (rsp_text),
        .rsp_tag       (rsp_tag),
        .rsp_timeout   (rsp_timeout),
        .busy          (busy)
    );

    function automatic logic [Y-1:0] eng_fn_text(input logic [Y-1:0] d, input logic dec);
        return dec ? ~d : (d ^ 40'h5A5A5A5A5A);
    endfunction

    function automatic logic [TAG_W-1:0] eng_fn_tag(input logic [Y-1:0] d, input logic dec);
        return {48'h0, d, d} ^ {127'h0, dec};
    endfunction

    task automatic chk(input string tag, input logic [TAG_W-1:0] obs, input logic [TAG_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural engine: completes eng_lat cycles after start rises, injects noise on ignored inputs.
    initial begin
        eng_enc_ready = 1'b0;
        eng_dec_ready = 1'b0;
        eng_text      = '0;
        eng_tag       = '0;
        ecnt          = 0;
        forever begin
            @(negedge clk);
            eng_enc_ready = 1'b0;
            eng_dec_ready = 1'b0;
            if (eng_enc_start || eng_dec_start) begin
                ecnt++;
                if (!eng_hang && ecnt == eng_lat) begin
                    if (eng_dec_start) eng_dec_ready = 1'b1;
                    else               eng_enc_ready = 1'b1;
                    eng_text = fix_en ? fix_text : eng_fn_text(eng_din, eng_dec_start);
                    eng_tag  = fix_en ? fix_tag  : eng_fn_tag(eng_din, eng_dec_start);
                end else if (eng_noise) begin
                    eng_text = Y'({$urandom, $urandom});
                    eng_tag  = {$urandom, $urandom, $urandom, $urandom};
                    if (eng_dec_start) eng_enc_ready = 1'($urandom_range(0, 1));
                    else               eng_dec_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                ecnt = 0;
                if (eng_noise) begin
                    eng_enc_ready = 1'($urandom_range(0, 1));
                    eng_dec_ready = 1'($urandom_range(0, 1));
                    eng_text      = Y'({$urandom, $urandom});
                    eng_tag       = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    function automatic int exp_winner();
        for (int k = 1; k <= N; k++) begin
            if (pv[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pv[i];
            req_mode[i]          = pm[i];
            req_data[i*Y +: Y]   = pd[i];
        end
    endtask

    task automatic new_req(input int i);
        pv[i] = 1'b1;
        pm[i] = 1'($urandom_range(0, 1));
        pd[i] = Y'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr = N - 1;
    endtask

    // One full job from IDLE: grant, engine run, response, optional backpressure, handshake.
    task automatic run_job(input int bp, input bit refill, input bit expect_tmo);
        int               w;
        int               st;
        bit               got;
        logic             m;
        logic [Y-1:0]     d;
        logic [Y-1:0]     et;
        logic [TAG_W-1:0] etag;

        w = exp_winner();
        if (w < 0) begin
            new_req(0);
            w = 0;
        end
        drive_reqs();
        m = pm[w];
        d = pd[w];
        @(negedge clk);
        chk("grant_onehot", req_ready, 1 << w);
        chk("grant_busy", busy, 1);
        chk("grant_enc_start", eng_enc_start, !m);
        chk("grant_dec_start", eng_dec_start, m);
        chk("grant_din", eng_din, d);
        pv[w] = 1'b0;
        if (refill) new_req(w);
        drive_reqs();

        if (expect_tmo) begin
            et   = '0;
            etag = '0;
        end else begin
            et   = fix_en ? fix_text : eng_fn_text(d, m);
            etag = fix_en ? fix_tag  : eng_fn_tag(d, m);
        end

        st  = 1;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (eng_enc_start || eng_dec_start) st++;
            chk("run_no_grant", req_ready, 0);
            chk("run_din_hold", eng_din, d);
        end
        chk("rsp_seen", got, 1);
        chk("start_cycles", st, expect_tmo ? TMO : eng_lat);
        chk("rsp_id", rsp_id, w);
        chk("rsp_mode", rsp_mode, m);
        chk("rsp_text", rsp_text, et);
        chk("rsp_tag", rsp_tag, etag);
        chk("rsp_timeout", rsp_timeout, expect_tmo);
        chk("rsp_starts_low", {eng_enc_start, eng_dec_start}, 0);
        chk("rsp_busy", busy, 1);

        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_text", rsp_text, et);
            chk("bp_tag", rsp_tag, etag);
            chk("bp_id", rsp_id, w);
            chk("bp_no_grant", req_ready, 0);
            chk("bp_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hs_valid_low", rsp_valid, 0);
        chk("hs_idle", busy, 0);
        chk("hs_no_grant", req_ready, 0);
        chk("hs_timeout_clr", rsp_timeout, 0);
        ptr = w;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_mode  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        fix_text  = '0;
        fix_tag   = '0;
        ptr       = N - 1;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pm[i] = 1'b0;
            pd[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_enc_start", eng_enc_start, 0);
        chk("rst_dec_start", eng_dec_start, 0);
        chk("rst_din", eng_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_mode", rsp_mode, 0);
        chk("rst_rsp_text", rsp_text, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // Single encrypt with a fixed engine result.
        fix_en   = 1;
        fix_text = 40'hA5A5A5A5A5;
        fix_tag  = 128'h1;
        eng_lat  = 10;
        pv[0] = 1'b1; pm[0] = 1'b0; pd[0] = 40'h0011223344;
        run_job(0, 0, 0);
        fix_en = 0;

        // Simultaneous requests after reset: 0 first, then 1 in decrypt mode.
        do_reset();
        eng_lat = 3;
        pv[0] = 1'b1; pm[0] = 1'b0; pd[0] = 40'h1234567890;
        pv[1] = 1'b1; pm[1] = 1'b1; pd[1] = 40'hFEDCBA9876;
        run_job(0, 0, 0);
        run_job(0, 0, 0);

        // Fairness: both requesters re-request immediately for six jobs.
        do_reset();
        new_req(0);
        new_req(1);
        for (int j = 0; j < 6; j++) run_job(0, 1, 0);
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        // Backpressure for five cycles, with the other requester waiting.
        eng_lat = 2;
        new_req(0);
        new_req(1);
        run_job(5, 0, 0);
        run_job(0, 0, 0);

        // Reset during RUN discards the job and restores the pointer.
        eng_lat = 50;
        pv[0] = 1'b0;
        new_req(1);
        drive_reqs();
        @(negedge clk);
        chk("mid_grant", req_ready, 2);
        pv[1] = 1'b0;
        drive_reqs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr = N - 1;
        chk("mid_starts_drop", {eng_enc_start, eng_dec_start}, 0);
        chk("mid_no_rsp", rsp_valid, 0);
        chk("mid_idle", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_quiet", rsp_valid, 0);
        end
        eng_lat = 4;
        new_req(0);
        new_req(1);
        run_job(0, 0, 0);
        pv[1] = 1'b0;
        do_reset();
        new_req(1);
        run_job(0, 0, 0);

        // Randomised traffic with engine noise on ignored inputs.
        eng_noise = 1;
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < N; i++) begin
                if (pv[i]) begin
                    if ($urandom_range(0, 9) == 0) pv[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    new_req(i);
                end
            end
            if (exp_winner() < 0) new_req(int'($urandom_range(0, N - 1)));
            eng_lat = int'($urandom_range(1, 6));
            run_job(int'($urandom_range(0, 3)), 0, 0);
        end
        eng_noise = 0;
        for (int i = 0; i < N; i++) pv[i] = 1'b0;
        drive_reqs();

`ifdef ASCON_ARB_TIMEOUT_EN
        // Engine never completes: watchdog response.
        do_reset();
        eng_hang = 1;
        new_req(0);
        run_job(2, 0, 1);
        eng_hang = 0;
        // Ready on the expiry cycle wins over the timeout.
        eng_lat = TMO;
        new_req(1);
        run_job(0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
